// File: rtl/sign_restore_unit_pkg.sv
// Shared definitions for the sign restore unit: default widths, ONE, mode
// encodings and the per-sample sign FIFO entry layout {neg, mode}.
// Latency: n/a (declarations only). Backpressure: n/a.
package sign_restore_unit_pkg;

    localparam int X_DW       = 16;
    localparam int Y_DW       = 16;
    localparam int Y_FRAC     = 14;
    localparam int SIGN_DEPTH = 8;

    // 1.0 in the core's output format
    localparam logic [Y_DW-1:0] ONE = Y_DW'(1 << Y_FRAC);

    typedef enum logic {
        MODE_SIGMOID = 1'b0,
        MODE_TANH    = 1'b1
    } mode_e;

    typedef struct packed {
        logic  neg;
        mode_e mode;
    } sign_entry_t;

endpackage

// File: rtl/sign_restore_unit_if.sv
// Datapath bundle of the sign restore unit: sample in, comparator result,
// |x| to the core, core result back, sign-restored activation out.
// Latency: n/a. Backpressure: none, valid-only qualifiers throughout.
interface sign_restore_unit_if
    import sign_restore_unit_pkg::*;
#(
    parameter int xDW = X_DW,
    parameter int yDW = Y_DW
);
    logic                  en;
    logic                  mode;
    logic signed [xDW-1:0] x;
    logic                  x_valid;
    logic                  ge;
    logic                  ge_valid;
    logic signed [xDW-1:0] abs_out;
    logic                  abs_valid;
    logic signed [yDW-1:0] core_y;
    logic                  core_valid;
    logic signed [yDW-1:0] y;
    logic                  y_valid;

    // master: the surrounding datapath; slave: the sign restore unit
    modport master (
        output en, mode, x, x_valid, ge, ge_valid, core_y, core_valid,
        input  abs_out, abs_valid, y, y_valid
    );
    modport slave (
        input  en, mode, x, x_valid, ge, ge_valid, core_y, core_valid,
        output abs_out, abs_valid, y, y_valid
    );
endinterface

// File: rtl/sign_restore_unit_sign_fifo.sv
// Sign FIFO: DEPTH x {neg, mode}; caller qualifies push/pop (no push when
// full without pop, no pop when empty). Latency: head visible 1 cycle after push.
// Backpressure: none; level exposes occupancy, MSB of level set means full.
module sign_restore_unit_sign_fifo
    import sign_restore_unit_pkg::*;
#(
    parameter int DEPTH = SIGN_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  sign_entry_t              din,
    output sign_entry_t              dout,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    sign_entry_t   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // pointers carry one extra wrap bit so full and empty differ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;
endmodule

// File: rtl/sign_restore_unit.sv
// Folds x to |x| for the magnitude-only activation core, queues each sample's
// sign and restores sigmoid/tanh symmetry on the returning core result.
// Latency: x -> abs_out 2 cycles, core_valid -> y 1 cycle. Backpressure: none;
// a push into a full queue is dropped. Ports: clk, rst, bus (slave modport);
// with SIGN_RESTORE_FLAGS_EN defined also fifo_level, overflow, underflow.
module sign_restore_unit
    import sign_restore_unit_pkg::*;
#(
    parameter int xDW   = X_DW,
    parameter int yDW   = Y_DW,
    parameter int YFRAC = Y_FRAC,
    parameter int DEPTH = SIGN_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    sign_restore_unit_if.slave     bus
`ifdef SIGN_RESTORE_FLAGS_EN
    ,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic                   underflow
`endif
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic signed [xDW-1:0] X_MIN = {1'b1, {(xDW-1){1'b0}}};
    localparam logic signed [xDW-1:0] X_MAX = {1'b0, {(xDW-1){1'b1}}};
    localparam logic signed [yDW:0]   ONE_W = {{(yDW-YFRAC){1'b0}}, 1'b1, {YFRAC{1'b0}}};

    // Stage A: hold the sample until its comparator result arrives
    logic signed [xDW-1:0] x_d;
    mode_e                 mode_d;
    logic                  xv_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_d    <= '0;
            mode_d <= MODE_SIGMOID;
            xv_d   <= 1'b0;
        end else begin
            xv_d <= bus.x_valid & bus.en;
            if (bus.x_valid & bus.en) begin
                x_d    <= bus.x;
                mode_d <= mode_e'(bus.mode);
            end
        end
    end

    // Stage B: fold to magnitude; the most negative input has no positive twin
    logic                  push_req;
    logic signed [xDW-1:0] abs_next;

    assign push_req = bus.ge_valid & xv_d;

    always_comb begin
        abs_next = x_d;
        if (!bus.ge) abs_next = (x_d == X_MIN) ? X_MAX : -x_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.abs_out   <= '0;
            bus.abs_valid <= 1'b0;
        end else begin
            bus.abs_valid <= push_req;
            if (push_req) bus.abs_out <= abs_next;
        end
    end

    // Sign queue; a pop into an empty queue never bypasses a same-cycle push
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          pop_ok;
    logic          push_ok;
    sign_entry_t   push_entry;
    sign_entry_t   head;

    assign full       = level[LW-1];
    assign empty      = (level == '0);
    assign pop_ok     = bus.core_valid & ~empty;
    assign push_ok    = push_req & (~full | pop_ok);
    assign push_entry = '{neg: ~bus.ge, mode: mode_d};

    sign_restore_unit_sign_fifo #(.DEPTH(DEPTH)) u_sign_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop_ok),
        .din   (push_entry),
        .dout  (head),
        .level (level)
    );

    // Stage C: sigmoid(-x) = ONE - sigmoid(|x|), tanh(-x) = -tanh(|x|)
    logic signed [yDW:0]   comp;
    logic signed [yDW-1:0] y_next;

    always_comb begin
        comp   = ONE_W - {bus.core_y[yDW-1], bus.core_y};
        y_next = bus.core_y;
        if (head.neg) begin
            if (head.mode == MODE_TANH) y_next = -bus.core_y;
            else if (comp < 0)          y_next = '0;
            else if (comp > ONE_W)      y_next = ONE_W[yDW-1:0];
            else                        y_next = comp[yDW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.y       <= '0;
            bus.y_valid <= 1'b0;
        end else begin
            bus.y_valid <= pop_ok;
            if (pop_ok) bus.y <= y_next;
        end
    end

`ifdef SIGN_RESTORE_FLAGS_EN
    assign fifo_level = level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_req & full & ~pop_ok) overflow  <= 1'b1;
            if (bus.core_valid & empty)    underflow <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sign_restore_unit.sv
// Testbench for sign_restore_unit: directed symmetry cases, back-to-back and
// randomized traffic against a queue-based reference model, overflow and reset.
// Clock period 10; inputs driven just after the rising edge, outputs read #1 later.
module tb_sign_restore_unit;
    import sign_restore_unit_pkg::*;

    localparam int DEPTH = SIGN_DEPTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sign_restore_unit_if #(.xDW(X_DW), .yDW(Y_DW)) bus ();

`ifdef SIGN_RESTORE_FLAGS_EN
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   overflow;
    logic                   underflow;
`endif

    sign_restore_unit #(.xDW(X_DW), .yDW(Y_DW), .YFRAC(Y_FRAC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SIGN_RESTORE_FLAGS_EN
        ,
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    bit          q_neg[$];
    mode_e       q_mode[$];
    bit          prev_xv, prev_acc;
    logic [15:0] prev_x;
    mode_e       prev_mode;
    logic        exp_av, exp_yv, exp_ovf, exp_udf;
    logic [15:0] exp_abs, exp_y;

    function automatic logic [15:0] abs_sat(input logic [15:0] v);
        int i;
        i = $signed(v);
        if (i < 0) i = -i;
        if (i > 32767) i = 32767;
        return i[15:0];
    endfunction

    function automatic logic [15:0] restore(input bit neg, input mode_e m, input logic [15:0] cy);
        int c, r;
        c = $signed(cy);
        if (!neg) r = c;
        else if (m == MODE_TANH) r = -c;
        else begin
            r = int'(ONE) - c;
            if (r < 0) r = 0;
            if (r > int'(ONE)) r = int'(ONE);
        end
        return r[15:0];
    endfunction

    task automatic model_clear();
        q_neg.delete();
        q_mode.delete();
        prev_xv = 1'b0; prev_acc = 1'b0; prev_x = '0; prev_mode = MODE_SIGMOID;
        exp_av = 1'b0; exp_yv = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
        exp_abs = '0; exp_y = '0;
    endtask

    task automatic drive_idle();
        bus.en = 1'b1; bus.mode = 1'b0; bus.x = '0; bus.x_valid = 1'b0;
        bus.ge = 1'b0; bus.ge_valid = 1'b0; bus.core_y = '0; bus.core_valid = 1'b0;
    endtask

    // One clock: drive inputs (comparator result of the previous sample),
    // advance the reference model, then clock and settle.
    task automatic step(input bit xv, input logic [15:0] xin, input bit md,
                        input bit cv, input logic [15:0] cy, input bit enable);
        int    sz;
        bit    push_now, pop_now, n;
        mode_e m;
        bus.en = enable; bus.x = xin; bus.x_valid = xv; bus.mode = md;
        bus.ge_valid = prev_xv; bus.ge = ($signed(prev_x) >= 0);
        bus.core_valid = cv; bus.core_y = cy;
        sz       = q_neg.size();
        push_now = prev_acc;
        pop_now  = cv && (sz > 0);
        exp_av   = push_now;
        exp_yv   = pop_now;
        if (cv && sz == 0) exp_udf = 1'b1;
        if (pop_now) begin
            n = q_neg.pop_front();
            m = q_mode.pop_front();
            exp_y = restore(n, m, cy);
        end
        if (push_now) begin
            exp_abs = abs_sat(prev_x);
            if (sz < DEPTH || pop_now) begin
                q_neg.push_back($signed(prev_x) < 0);
                q_mode.push_back(prev_mode);
            end else exp_ovf = 1'b1;
        end
        @(posedge clk); #1;
        prev_xv   = xv;
        prev_acc  = xv && enable;
        if (xv && enable) begin
            prev_x    = xin;
            prev_mode = mode_e'(md);
        end
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        total += 4;
        if (bus.abs_out !== 16'h0)  begin bad++; $display("FAIL reset_abs_out got=%h want=0000", bus.abs_out); end
        if (bus.abs_valid !== 1'b0) begin bad++; $display("FAIL reset_abs_valid got=%b want=0", bus.abs_valid); end
        if (bus.y !== 16'h0)        begin bad++; $display("FAIL reset_y got=%h want=0000", bus.y); end
        if (bus.y_valid !== 1'b0)   begin bad++; $display("FAIL reset_y_valid got=%b want=0", bus.y_valid); end
`ifdef SIGN_RESTORE_FLAGS_EN
        total += 3;
        if (fifo_level !== '0)   begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
        if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        if (underflow !== 1'b0)  begin bad++; $display("FAIL reset_underflow got=%b want=0", underflow); end
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
    endtask

    // directed: one sample through, fixed expected abs and y
    task automatic test_directed(input string name, input logic [15:0] xin, input bit md,
                                 input logic [15:0] want_abs, input logic [15:0] cy,
                                 input logic [15:0] want_y);
        step(1'b1, xin, md, 1'b0, '0, 1'b1);
        total++;
        if (bus.abs_valid !== 1'b0) begin bad++; $display("FAIL %s_abs_early got=%b want=0", name, bus.abs_valid); end
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        total += 2;
        if (bus.abs_valid !== 1'b1) begin bad++; $display("FAIL %s_abs_valid got=%b want=1", name, bus.abs_valid); end
        if (bus.abs_out !== want_abs) begin bad++; $display("FAIL %s_abs_out got=%h want=%h", name, bus.abs_out, want_abs); end
        step(1'b0, '0, 1'b0, 1'b1, cy, 1'b1);
        total += 2;
        if (bus.y_valid !== 1'b1) begin bad++; $display("FAIL %s_y_valid got=%b want=1", name, bus.y_valid); end
        if (bus.y !== want_y)     begin bad++; $display("FAIL %s_y got=%h want=%h", name, bus.y, want_y); end
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        total++;
        if (bus.y_valid !== 1'b0) begin bad++; $display("FAIL %s_y_valid_drop got=%b want=0", name, bus.y_valid); end
    endtask

    task automatic test_back_to_back();
        int          outs = 0;
        logic [15:0] mag, xin;
        for (int s = 0; s < 12; s++) begin
            mag = 16'($urandom_range(1, 16'h3FFF));
            xin = (s % 2 == 1) ? 16'(-$signed(mag)) : mag;
            step(s < 8, xin, s[1], (s >= 4), 16'($urandom_range(0, int'(ONE))), 1'b1);
            total += 2;
            if (bus.abs_valid !== exp_av) begin bad++; $display("FAIL b2b_abs_valid s=%0d got=%b want=%b", s, bus.abs_valid, exp_av); end
            if (bus.y_valid !== exp_yv)   begin bad++; $display("FAIL b2b_y_valid s=%0d got=%b want=%b", s, bus.y_valid, exp_yv); end
            if (exp_av) begin
                total++;
                if (bus.abs_out !== exp_abs) begin bad++; $display("FAIL b2b_abs_out s=%0d got=%h want=%h", s, bus.abs_out, exp_abs); end
            end
            if (exp_yv) begin
                total++;
                if (bus.y !== exp_y) begin bad++; $display("FAIL b2b_y s=%0d got=%h want=%h", s, bus.y, exp_y); end
            end
            if (bus.y_valid === 1'b1) outs++;
`ifdef SIGN_RESTORE_FLAGS_EN
            total++;
            if (fifo_level > 4) begin bad++; $display("FAIL b2b_level s=%0d got=%0d want<=4", s, fifo_level); end
`endif
        end
        total++;
        if (outs != 8) begin bad++; $display("FAIL b2b_out_count got=%0d want=8", outs); end
    endtask

    task automatic test_random();
        for (int s = 0; s < 400; s++) begin
            step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 6, 16'($urandom_range(0, int'(ONE) + 64)),
                 $urandom_range(0, 9) != 0);
            total += 2;
            if (bus.abs_valid !== exp_av) begin bad++; $display("FAIL rnd_abs_valid s=%0d got=%b want=%b", s, bus.abs_valid, exp_av); end
            if (bus.y_valid !== exp_yv)   begin bad++; $display("FAIL rnd_y_valid s=%0d got=%b want=%b", s, bus.y_valid, exp_yv); end
            if (exp_av) begin
                total++;
                if (bus.abs_out !== exp_abs) begin bad++; $display("FAIL rnd_abs_out s=%0d got=%h want=%h", s, bus.abs_out, exp_abs); end
            end
            if (exp_yv) begin
                total++;
                if (bus.y !== exp_y) begin bad++; $display("FAIL rnd_y s=%0d got=%h want=%h", s, bus.y, exp_y); end
            end
        end
`ifdef SIGN_RESTORE_FLAGS_EN
        total += 2;
        if (overflow !== exp_ovf)  begin bad++; $display("FAIL rnd_overflow got=%b want=%b", overflow, exp_ovf); end
        if (underflow !== exp_udf) begin bad++; $display("FAIL rnd_underflow got=%b want=%b", underflow, exp_udf); end
`endif
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int s = 0; s < 10; s++) begin
            step(s < 9, 16'(16'h0100 * (s + 1)), 1'b0, 1'b0, '0, 1'b1);
            total++;
            if (bus.abs_valid !== (s >= 1)) begin bad++; $display("FAIL ovf_abs_valid s=%0d got=%b want=%b", s, bus.abs_valid, s >= 1); end
        end
`ifdef SIGN_RESTORE_FLAGS_EN
        total += 2;
        if (overflow !== 1'b1)   begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d want=8", fifo_level); end
`endif
        for (int k = 0; k < 9; k++) begin
            step(1'b0, '0, 1'b0, 1'b1, 16'(16'h0200 * (k + 1)), 1'b1);
            total++;
            if (bus.y_valid !== (k < 8)) begin bad++; $display("FAIL ovf_y_valid k=%0d got=%b want=%b", k, bus.y_valid, k < 8); end
            if (k < 8) begin
                total++;
                if (bus.y !== 16'(16'h0200 * (k + 1))) begin bad++; $display("FAIL ovf_y k=%0d got=%h want=%h", k, bus.y, 16'(16'h0200 * (k + 1))); end
            end
        end
`ifdef SIGN_RESTORE_FLAGS_EN
        total++;
        if (underflow !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b want=1", underflow); end
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int s = 0; s < 4; s++) step(1'b1, 16'(16'hF000 + s), 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, 16'h2000, 1'b1);
        total += 2;
        if (bus.y_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_y_valid got=%b want=1", bus.y_valid); end
        if (bus.y !== exp_y)      begin bad++; $display("FAIL rmid_pre_y got=%h want=%h", bus.y, exp_y); end
        drive_idle();
        rst = 1'b1;
        #1;
        total += 4;
        if (bus.y !== 16'h0)        begin bad++; $display("FAIL rmid_y got=%h want=0000", bus.y); end
        if (bus.y_valid !== 1'b0)   begin bad++; $display("FAIL rmid_y_valid got=%b want=0", bus.y_valid); end
        if (bus.abs_out !== 16'h0)  begin bad++; $display("FAIL rmid_abs_out got=%h want=0000", bus.abs_out); end
        if (bus.abs_valid !== 1'b0) begin bad++; $display("FAIL rmid_abs_valid got=%b want=0", bus.abs_valid); end
`ifdef SIGN_RESTORE_FLAGS_EN
        total++;
        if (fifo_level !== '0) begin bad++; $display("FAIL rmid_level got=%0d want=0", fifo_level); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        // stale core result after reset finds nothing queued
        step(1'b0, '0, 1'b0, 1'b1, 16'h1111, 1'b1);
        total++;
        if (bus.y_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale_y_valid got=%b want=0", bus.y_valid); end
`ifdef SIGN_RESTORE_FLAGS_EN
        total++;
        if (underflow !== 1'b1) begin bad++; $display("FAIL rmid_underflow got=%b want=1", underflow); end
`endif
        test_directed("rmid_next", 16'hF000, 1'b0, 16'h1000, 16'h2500, 16'h1B00);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_directed("sig_pos",  16'h2000, 1'b0, 16'h2000, 16'h3000, 16'h3000);
        test_directed("sig_neg",  16'hE000, 1'b0, 16'h2000, 16'h3000, 16'h1000);
        test_directed("tanh_sat", 16'h8000, 1'b1, 16'h7FFF, 16'h3FFF, 16'hC001);
        test_directed("tanh_pos", 16'h1234, 1'b1, 16'h1234, 16'h0ABC, 16'h0ABC);
        test_directed("sig_clip", 16'hFFFF, 1'b0, 16'h0001, 16'h4000, 16'h0000);
        test_back_to_back();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
